// File: rtl/pfd_loop_filter.sv
// pfd_loop_filter: proportional-integral loop filter fed by asynchronous pfd
// up/down pulses. Synchronises the pulses, integrates the error into a
// saturating accumulator, and drives a saturated DCO control word. It also
// reports clamping and a windowed lock indication.
module pfd_loop_filter #(
   parameter int CW_W      = 10,
   parameter int KI_SHIFT  = 4,
   parameter int KP        = 8,
   parameter int CW_INIT   = 512,
   parameter int WIN       = 32,
   parameter int TOL       = 2,
   parameter int LOCK_WINS = 4
) (
   input  logic            refclk,
   input  logic            rst,
   input  logic            en,
   input  logic            up,
   input  logic            down,
   output logic [CW_W-1:0] ctrl_word,
   output logic            ctrl_valid,
   output logic            sat,
   output logic            locked
);

   localparam int ACC_W = CW_W + KI_SHIFT;
   localparam int AS_W  = ACC_W + 2;
   localparam int CS_W  = CW_W + $clog2(KP + 1) + 2;
   localparam int WC_W  = $clog2(WIN + 1);
   localparam int WS_W  = $clog2(WIN + 1) + 2;
   localparam int GC_W  = $clog2(LOCK_WINS + 1);

   localparam logic signed [AS_W-1:0] ACC_MAX_S = AS_W'((1 << ACC_W) - 1);
   localparam logic signed [CS_W-1:0] CW_MAX_S  = CS_W'((1 << CW_W) - 1);
   localparam logic signed [CS_W-1:0] KP_S      = CS_W'(KP);
   localparam logic signed [WS_W-1:0] TOL_P     = WS_W'(TOL);
   localparam logic signed [WS_W-1:0] TOL_N     = -WS_W'(TOL);
   localparam logic [ACC_W-1:0]       ACC_INIT  = ACC_W'(CW_INIT) << KI_SHIFT;
   localparam logic [WC_W-1:0]        WIN_LAST  = WC_W'(WIN - 1);
   localparam logic [GC_W-1:0]        GOOD_LAST = GC_W'(LOCK_WINS - 1);

   localparam logic [0:0] S_ACQUIRE = 1'b0;
   localparam logic [0:0] S_LOCKED  = 1'b1;

   logic                    up_m, up_s, down_m, down_s;
   logic signed [1:0]       err;
   logic [ACC_W-1:0]        acc, acc_n;
   logic signed [AS_W-1:0]  acc_sum;
   logic                    acc_clamp;
   logic signed [CS_W-1:0]  ctrl_base, ctrl_sum;
   logic [CW_W-1:0]         ctrl_n;
   logic                    ctrl_clamp;
   logic [WC_W-1:0]         win_cnt;
   logic signed [WS_W-1:0]  win_sum, win_sum_n;
   logic                    win_end, win_good;
   logic [0:0]              state;
   logic [GC_W-1:0]         good_cnt;
   logic [1:0]              bad_cnt;

   // Two-flop synchronisers; they keep running while en is low
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         up_m   <= 1'b0;
         up_s   <= 1'b0;
         down_m <= 1'b0;
         down_s <= 1'b0;
      end else begin
         up_m   <= up;
         up_s   <= up_m;
         down_m <= down;
         down_s <= down_m;
      end
   end

   // Phase error, accumulator/control-word clamping and window arithmetic
   always_comb begin
      err = 2'sd0;
      if (up_s && !down_s)      err = 2'sd1;
      else if (down_s && !up_s) err = -2'sd1;

      acc_sum   = $signed({2'b00, acc}) + $signed({{(AS_W-2){err[1]}}, err});
      acc_clamp = 1'b0;
      acc_n     = acc_sum[ACC_W-1:0];
      if (acc_sum[AS_W-1]) begin
         acc_n     = '0;
         acc_clamp = 1'b1;
      end else if (acc_sum > ACC_MAX_S) begin
         acc_n     = '1;
         acc_clamp = 1'b1;
      end

      ctrl_base = $signed({{(CS_W-CW_W){1'b0}}, acc_n[ACC_W-1:KI_SHIFT]});
      ctrl_sum  = ctrl_base;
      if (err == 2'sd1)       ctrl_sum = ctrl_base + KP_S;
      else if (err == -2'sd1) ctrl_sum = ctrl_base - KP_S;
      ctrl_clamp = 1'b0;
      ctrl_n     = ctrl_sum[CW_W-1:0];
      if (ctrl_sum[CS_W-1]) begin
         ctrl_n     = '0;
         ctrl_clamp = 1'b1;
      end else if (ctrl_sum > CW_MAX_S) begin
         ctrl_n     = '1;
         ctrl_clamp = 1'b1;
      end

      win_sum_n = win_sum + $signed({{(WS_W-2){err[1]}}, err});
      win_end   = (win_cnt == WIN_LAST);
      win_good  = (win_sum_n <= TOL_P) && (win_sum_n >= TOL_N);
   end

   // Filter state and lock-window accumulation, frozen while en is low
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         acc        <= ACC_INIT;
         ctrl_word  <= CW_W'(CW_INIT);
         ctrl_valid <= 1'b0;
         sat        <= 1'b0;
         win_cnt    <= '0;
         win_sum    <= '0;
      end else if (en) begin
         acc        <= acc_n;
         ctrl_word  <= ctrl_n;
         ctrl_valid <= 1'b1;
         sat        <= acc_clamp | ctrl_clamp;
         if (win_end) begin
            win_cnt <= '0;
            win_sum <= '0;
         end else begin
            win_cnt <= win_cnt + WC_W'(1);
            win_sum <= win_sum_n;
         end
      end
   end

   // Lock FSM, advanced only on the enabled edge that closes a window
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state    <= S_ACQUIRE;
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else if (en && win_end) begin
         case (state)
            S_ACQUIRE: begin
               if (win_good) begin
                  good_cnt <= good_cnt + GC_W'(1);
                  if (good_cnt == GOOD_LAST) begin
                     state   <= S_LOCKED;
                     bad_cnt <= '0;
                  end
               end else begin
                  good_cnt <= '0;
               end
            end
            default: begin
               if (win_good) begin
                  bad_cnt <= '0;
               end else if (bad_cnt == 2'd1) begin
                  state    <= S_ACQUIRE;
                  good_cnt <= '0;
                  bad_cnt  <= '0;
               end else begin
                  bad_cnt <= bad_cnt + 2'd1;
               end
            end
         endcase
      end
   end

   assign locked = (state == S_LOCKED);

endmodule

// File: tb/tb_pfd_loop_filter.sv
// Testbench for pfd_loop_filter: directed scenarios plus random traffic,
// checked against a behavioural model built from delay lines and integers.
module tb_pfd_loop_filter;

   logic       refclk = 1'b0;
   logic       rst, en, up, down;
   logic [9:0] ctrl_word;
   logic       ctrl_valid, sat, locked;

   int checks = 0;
   int errors = 0;

   // model state
   int m_acc, m_ctrl, m_wcnt, m_wsum, m_gcnt, m_bcnt;
   bit m_sat, m_valid, m_lock;
   bit hu[2];
   bit hd[2];

   pfd_loop_filter #(
      .CW_W(10), .KI_SHIFT(4), .KP(8), .CW_INIT(512),
      .WIN(32), .TOL(2), .LOCK_WINS(4)
   ) dut (
      .refclk(refclk), .rst(rst), .en(en), .up(up), .down(down),
      .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid), .sat(sat), .locked(locked)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 512 * 16; m_ctrl = 512; m_sat = 0; m_valid = 0; m_lock = 0;
      m_wcnt = 0; m_wsum = 0; m_gcnt = 0; m_bcnt = 0;
      hu = '{0, 0}; hd = '{0, 0};
   endtask

   task automatic model_edge(input bit u, input bit d, input bit e_en);
      int e, a, c;
      bit good;
      e = 0;
      if (hu[0] && !hd[0]) e = 1;
      if (hd[0] && !hu[0]) e = -1;
      hu[0] = hu[1]; hu[1] = u;
      hd[0] = hd[1]; hd[1] = d;
      if (e_en) begin
         a = m_acc + e;
         m_sat = 0;
         if (a < 0)     begin a = 0;     m_sat = 1; end
         if (a > 16383) begin a = 16383; m_sat = 1; end
         m_acc = a;
         c = a / 16 + 8 * e;
         if (c < 0)    begin c = 0;    m_sat = 1; end
         if (c > 1023) begin c = 1023; m_sat = 1; end
         m_ctrl = c;
         m_valid = 1;
         m_wsum += e;
         m_wcnt++;
         if (m_wcnt == 32) begin
            good = (m_wsum >= -2) && (m_wsum <= 2);
            m_wsum = 0;
            m_wcnt = 0;
            if (!m_lock) begin
               m_gcnt = good ? m_gcnt + 1 : 0;
               if (m_gcnt >= 4) begin m_lock = 1; m_bcnt = 0; end
            end else begin
               m_bcnt = good ? 0 : m_bcnt + 1;
               if (m_bcnt >= 2) begin m_lock = 0; m_gcnt = 0; m_bcnt = 0; end
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("ctrl_word", ctrl_word, m_ctrl);
      chk("ctrl_valid", ctrl_valid, m_valid);
      chk("sat", sat, m_sat);
      chk("locked", locked, m_lock);
      chk("acc", dut.acc, m_acc);
      chk("win_sum", dut.win_sum, m_wsum);
   endtask

   // called at a falling edge; returns at the next falling edge
   task automatic step(input bit u, input bit d, input bit e_en);
      up = u; down = d; en = e_en;
      @(posedge refclk);
      model_edge(u, d, e_en);
      #1;
      compare_all();
      @(negedge refclk);
   endtask

   // asynchronous reset pulse asserted between edges
   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("rst_ctrl_word", ctrl_word, 512);
      chk("rst_ctrl_valid", ctrl_valid, 0);
      chk("rst_sat", sat, 0);
      chk("rst_locked", locked, 0);
      chk("rst_acc", dut.acc, 8192);
      @(negedge refclk);
      rst = 1'b0;
   endtask

   initial begin
      int saved;
      rst = 1'b1; en = 1'b0; up = 1'b0; down = 1'b0;
      model_reset();
      #1;
      chk("init_ctrl_word", ctrl_word, 512);
      chk("init_ctrl_valid", ctrl_valid, 0);
      chk("init_sat", sat, 0);
      chk("init_locked", locked, 0);
      @(negedge refclk);
      @(negedge refclk);
      rst = 1'b0;

      // up held: latency and integral ramp
      step(1, 0, 1);
      step(1, 0, 1);
      chk("lat_before", ctrl_word, 512);
      step(1, 0, 1);
      chk("lat_first", ctrl_word, 520);
      for (int i = 0; i < 15; i++) step(1, 0, 1);
      chk("ramp16_acc", dut.acc, 8208);
      chk("ramp16_ctrl", ctrl_word, 521);
      chk("ramp16_valid", ctrl_valid, 1);

      // reset mid-stream while up is still asserted
      pulse_reset();

      // down held to the floor, then up held to the ceiling
      for (int i = 0; i < 8300; i++) step(0, 1, 1);
      chk("floor_ctrl", ctrl_word, 0);
      chk("floor_sat", sat, 1);
      chk("floor_acc", dut.acc, 0);
      for (int i = 0; i < 16500; i++) step(1, 0, 1);
      chk("ceil_ctrl", ctrl_word, 1023);
      chk("ceil_sat", sat, 1);
      chk("ceil_acc", dut.acc, 16383);

      // both high: no movement
      pulse_reset();
      for (int i = 0; i < 100; i++) step(1, 1, 1);
      chk("both_ctrl", ctrl_word, 512);
      chk("both_sat", sat, 0);
      chk("both_acc", dut.acc, 8192);

      // alternating pulses lock; sustained up unlocks after two bad windows
      pulse_reset();
      for (int i = 0; i < 140; i++) step(i % 2 == 0, i % 2 == 1, 1);
      chk("lock_acq", locked, 1);
      for (int i = 0; i < 30; i++) step(1, 0, 1);
      chk("lock_one_bad", locked, 1);
      for (int i = 0; i < 40; i++) step(1, 0, 1);
      chk("lock_two_bad", locked, 0);

      // freeze with en low during an up ramp, then resume
      pulse_reset();
      for (int i = 0; i < 20; i++) step(1, 0, 1);
      saved = m_ctrl;
      for (int i = 0; i < 50; i++) step(1, 0, 0);
      chk("freeze_ctrl", ctrl_word, saved);
      for (int i = 0; i < 30; i++) step(1, 0, 1);

      // random traffic with a reset in the middle
      for (int i = 0; i < 600; i++) begin
         if (i == 300) pulse_reset();
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
